// File: rtl/fir_l3_pkg.sv
// Shared types for the 3-lane FIR stream controller.
package fir_l3_pkg;
    localparam int L     = 3;
    localparam int IN_W  = 16;
    localparam int OUT_W = 64;

    typedef logic [1:0] lane_cnt_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // lane[0] is lane 1 (oldest sample); tag is the number of real lanes.
    typedef struct packed {
        lane_cnt_t                tag;
        logic [L-1:0][OUT_W-1:0]  lane;
    } obuf_entry_t;
endpackage

// File: rtl/fir_l3_obuf.sv
// Synchronous FIFO of 3-lane FIR result entries with occupancy and free-space outputs.
module fir_l3_obuf
    import fir_l3_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  obuf_entry_t                push_data,
    input  logic                       pop,
    output obuf_entry_t                head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     free
);
    localparam int AW = $clog2(DEPTH);

    obuf_entry_t         mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != (AW+1)'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign free  = (AW+1)'(DEPTH) - count_q;
endmodule

// File: rtl/fir_l3_stream_ctrl.sv
// Serial-to-3-lane sequencer for the pipelined FIR: packs samples into beats, tracks
// which pipeline beats carry real samples, buffers results and re-serialises them.
module fir_l3_stream_ctrl
    import fir_l3_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = IN_W,
    parameter int DATA_OUT_WIDTH = OUT_W,
    parameter int FIR_LATENCY    = 4,
    parameter int OBUF_BEATS     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_IN_WIDTH-1:0]  s_data,
    input  logic                      flush,
    output logic                      fir_ce,
    output logic [DATA_IN_WIDTH-1:0]  fir_data_1,
    output logic [DATA_IN_WIDTH-1:0]  fir_data_2,
    output logic [DATA_IN_WIDTH-1:0]  fir_data_3,
    input  logic [DATA_OUT_WIDTH-1:0] fir_out_1,
    input  logic [DATA_OUT_WIDTH-1:0] fir_out_2,
    input  logic [DATA_OUT_WIDTH-1:0] fir_out_3,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_OUT_WIDTH-1:0] m_data,
    output logic                      busy,
    output logic                      flush_done,
    output logic                      dbg_state
);
    localparam int CW  = $clog2(OBUF_BEATS) + 1;
    localparam int DCW = $clog2(FIR_LATENCY + 1);

    state_t                    state_q, state_d;
    lane_cnt_t                 lane_cnt_q, lane_cnt_d, ce_tag_q, ce_tag_d, lane_idx_q, lane_idx_d;
    lane_cnt_t                 tag_q [FIR_LATENCY];
    lane_cnt_t                 tag_d [FIR_LATENCY];
    logic [DATA_IN_WIDTH-1:0]  grp_q [L];
    logic [DATA_IN_WIDTH-1:0]  grp_d [L];
    logic [DATA_IN_WIDTH-1:0]  beat_q [L];
    logic [DATA_IN_WIDTH-1:0]  beat_d [L];
    logic [DCW-1:0]            drain_cnt_q, drain_cnt_d;
    logic                      fir_ce_q, fir_ce_d, ce_dly_q, ce_dly_d;
    logic                      flush_done_q, flush_done_d, m_valid_q, m_valid_d;
    logic [DATA_OUT_WIDTH-1:0] m_data_q, m_data_d;

    logic                      issue, accept, can_issue, pending_push, push, pop;
    obuf_entry_t               push_entry, ob_head;
    logic [CW-1:0]             ob_count, ob_free;

    fir_l3_obuf #(.DEPTH(OBUF_BEATS)) u_obuf (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (ob_head),
        .count     (ob_count),
        .free      (ob_free)
    );

    // One beat in flight at a time: while fir_ce_q is high its push is not yet known,
    // and in the following cycle the push is counted as pending against free space.
    always_comb begin
        pending_push = ce_dly_q && (tag_q[FIR_LATENCY-1] != '0);
        can_issue    = !fir_ce_q && (ob_free > CW'(pending_push));
        issue        = 1'b0;
        s_ready      = 1'b0;
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        flush_done_d = 1'b0;
        case (state_q)
            COLLECT: begin
                issue   = (lane_cnt_q == 2'd3) && can_issue;
                s_ready = (lane_cnt_q != 2'd3) || issue;
                if (flush) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DCW'(FIR_LATENCY);
                end
            end
            DRAIN: begin
                if (drain_cnt_q != '0) begin
                    issue = can_issue;
                    if (issue) begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end else if (!fir_ce_q && !ce_dly_q) begin
                    flush_done_d = 1'b1;
                    state_d      = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        accept = s_valid && s_ready;
    end

    // Group assembly and beat issue; unused lanes of a partial beat go out as zero.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        grp_d      = grp_q;
        beat_d     = beat_q;
        ce_tag_d   = ce_tag_q;
        fir_ce_d   = issue;
        if (issue) begin
            ce_tag_d   = lane_cnt_q;
            lane_cnt_d = '0;
            for (int i = 0; i < L; i++) begin
                beat_d[i] = (lane_cnt_t'(i) < lane_cnt_q) ? grp_q[i] : '0;
            end
        end
        if (accept) begin
            if (issue) begin
                grp_d[0]   = s_data;
                lane_cnt_d = 2'd1;
            end else begin
                for (int i = 0; i < L; i++) begin
                    if (lane_cnt_q == lane_cnt_t'(i)) begin
                        grp_d[i] = s_data;
                    end
                end
                lane_cnt_d = lane_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        ce_dly_d = fir_ce_q;
        tag_d    = tag_q;
        if (fir_ce_q) begin
            tag_d[0] = ce_tag_q;
            for (int i = 1; i < FIR_LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
        push               = ce_dly_q && (tag_q[FIR_LATENCY-1] != '0);
        push_entry.tag     = tag_q[FIR_LATENCY-1];
        push_entry.lane[0] = fir_out_1;
        push_entry.lane[1] = fir_out_2;
        push_entry.lane[2] = fir_out_3;
    end

    // Serialiser: the output register reloads whenever it is empty or being taken.
    always_comb begin
        pop        = 1'b0;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        lane_idx_d = lane_idx_q;
        if (!m_valid_q || m_ready) begin
            m_valid_d = (ob_count != '0);
            if (ob_count != '0) begin
                for (int i = 0; i < L; i++) begin
                    if (lane_idx_q == lane_cnt_t'(i)) begin
                        m_data_d = ob_head.lane[i];
                    end
                end
                if (lane_cnt_t'(lane_idx_q + 2'd1) == ob_head.tag) begin
                    pop        = 1'b1;
                    lane_idx_d = '0;
                end else begin
                    lane_idx_d = lane_idx_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= COLLECT;
            lane_cnt_q   <= '0;
            ce_tag_q     <= '0;
            lane_idx_q   <= '0;
            tag_q        <= '{default: '0};
            grp_q        <= '{default: '0};
            beat_q       <= '{default: '0};
            drain_cnt_q  <= '0;
            fir_ce_q     <= 1'b0;
            ce_dly_q     <= 1'b0;
            flush_done_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            ce_tag_q     <= ce_tag_d;
            lane_idx_q   <= lane_idx_d;
            tag_q        <= tag_d;
            grp_q        <= grp_d;
            beat_q       <= beat_d;
            drain_cnt_q  <= drain_cnt_d;
            fir_ce_q     <= fir_ce_d;
            ce_dly_q     <= ce_dly_d;
            flush_done_q <= flush_done_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
        end
    end

    assign fir_ce     = fir_ce_q;
    assign fir_data_1 = beat_q[0];
    assign fir_data_2 = beat_q[1];
    assign fir_data_3 = beat_q[2];
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign flush_done = flush_done_q;
    assign busy       = (state_q == DRAIN) || (ob_count != '0) || m_valid_q;
    assign dbg_state  = logic'(state_q);
endmodule

// File: tb/tb_fir_l3_stream_ctrl.sv
// Bench for fir_l3_stream_ctrl with an identity 4-beat FIR stub and a sample-order model.
module tb_fir_l3_stream_ctrl;
    localparam int IW = 16;
    localparam int OW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid, s_ready, flush, fir_ce, m_valid, m_ready, busy, flush_done, dbg_state;
    logic [IW-1:0] s_data, fir_data_1, fir_data_2, fir_data_3;
    logic [OW-1:0] fir_out_1, fir_out_2, fir_out_3, m_data;

    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    logic [OW-1:0] exp_q[$];
    logic [IW-1:0] pend_q[$];
    logic [OW-1:0] out_log[$];
    logic [3*IW-1:0] beat_log[$];
    logic [IW-1:0] e0, e1, e2;
    logic          hold_q = 1'b0;
    logic [OW-1:0] hold_data_q = '0;

    always #5 clk = ~clk;

    fir_l3_stream_ctrl dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .flush(flush), .fir_ce(fir_ce), .fir_data_1(fir_data_1), .fir_data_2(fir_data_2),
        .fir_data_3(fir_data_3), .fir_out_1(fir_out_1), .fir_out_2(fir_out_2),
        .fir_out_3(fir_out_3), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .flush_done(flush_done), .dbg_state(dbg_state)
    );

    // Identity FIR: ce-gated 4-stage delay with sign extension, registered output.
    logic [OW-1:0] p1 [4];
    logic [OW-1:0] p2 [4];
    logic [OW-1:0] p3 [4];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                p1[i] <= '0; p2[i] <= '0; p3[i] <= '0;
            end
        end else if (fir_ce) begin
            p1[0] <= {{(OW-IW){fir_data_1[IW-1]}}, fir_data_1};
            p2[0] <= {{(OW-IW){fir_data_2[IW-1]}}, fir_data_2};
            p3[0] <= {{(OW-IW){fir_data_3[IW-1]}}, fir_data_3};
            for (int i = 1; i < 4; i++) begin
                p1[i] <= p1[i-1]; p2[i] <= p2[i-1]; p3[i] <= p3[i-1];
            end
        end
    end
    assign fir_out_1 = p1[3];
    assign fir_out_2 = p2[3];
    assign fir_out_3 = p3[3];

    function automatic logic [OW-1:0] sext(input logic [IW-1:0] v);
        return {{(OW-IW){v[IW-1]}}, v};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: every beat holds the next up-to-3 unissued samples (zero padded),
    // and every output handshake must deliver the oldest not-yet-emitted sample.
    always @(negedge clk) begin
        if (reset_n) begin
            if (fir_ce) begin
                e0 = (pend_q.size() > 0) ? pend_q.pop_front() : '0;
                e1 = (pend_q.size() > 0) ? pend_q.pop_front() : '0;
                e2 = (pend_q.size() > 0) ? pend_q.pop_front() : '0;
                check("fir_beat", {16'h0, fir_data_1, fir_data_2, fir_data_3}, {16'h0, e0, e1, e2});
                beat_log.push_back({fir_data_1, fir_data_2, fir_data_3});
            end
            if (s_valid && s_ready) begin
                pend_q.push_back(s_data);
                exp_q.push_back(sext(s_data));
            end
            if (m_valid && m_ready) begin
                out_log.push_back(m_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_extra: got %h expected no output", m_data);
                end else begin
                    check("m_data", m_data, exp_q.pop_front());
                end
            end
            if (hold_q) begin
                check("hold_valid", {63'd0, m_valid}, 64'd1);
                check("hold_data", m_data, hold_data_q);
            end
            hold_q      <= m_valid && !m_ready;
            hold_data_q <= m_data;
            if (flush_done) done_cnt <= done_cnt + 1;
        end else begin
            hold_q <= 1'b0;
        end
    end

    task automatic send(input logic [IW-1:0] v);
        int n = 0;
        s_valid = 1'b1;
        s_data  = v;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 1000);
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=0 expected 1 for sample %h", v);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_flush(input string name);
        int n;
        int d0;
        d0    = done_cnt;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        check({name, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_logs();
        beat_log.delete();
        out_log.delete();
    endtask

    initial begin
        int ce_seen;
        int mv_seen;
        logic [IW-1:0] v;
        s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fir_ce", {63'd0, fir_ce}, 64'd0);
        check("rst_fir_data", {16'h0, fir_data_1, fir_data_2, fir_data_3}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_flush_done", {63'd0, flush_done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
        ce_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (fir_ce) ce_seen++;
        end
        check("idle_ce", 64'(ce_seen), 64'd0);
        @(posedge clk); #1;

        // Samples 1..6, then flush
        clear_logs();
        for (int i = 1; i <= 6; i++) send(IW'(i));
        repeat (20) @(posedge clk);
        #1;
        check("t1_beats", 64'(beat_log.size()), 64'd2);
        if (beat_log.size() >= 2) begin
            check("t1_beat0", 64'(beat_log[0]), 64'h0000_0001_0002_0003);
            check("t1_beat1", 64'(beat_log[1]), 64'h0000_0004_0005_0006);
        end
        check("t1_no_out", 64'(out_log.size()), 64'd0);
        do_flush("t1");
        check("t1_beats_total", 64'(beat_log.size()), 64'd6);
        check("t1_out_cnt", 64'(out_log.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < out_log.size()) check("t1_out", out_log[i], 64'(i + 1));

        // Partial group 7..10
        clear_logs();
        for (int i = 7; i <= 10; i++) send(IW'(i));
        do_flush("t2");
        check("t2_beats_total", 64'(beat_log.size()), 64'd5);
        if (beat_log.size() >= 2) begin
            check("t2_beat0", 64'(beat_log[0]), 64'h0000_0007_0008_0009);
            check("t2_beat1", 64'(beat_log[1]), 64'h0000_000A_0000_0000);
        end
        check("t2_out_cnt", 64'(out_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < out_log.size()) check("t2_out", out_log[i], 64'(i + 7));

        // Backpressure: 40 samples with m_ready low until the buffer fills
        clear_logs();
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(IW'(i * 1237 - 20000));
            end
            begin
                repeat (150) @(posedge clk);
                ce_seen = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (fir_ce) ce_seen++;
                end
                check("t3_stall_ce", 64'(ce_seen), 64'd0);
                check("t3_stall_s_ready", {63'd0, s_ready}, 64'd0);
                check("t3_stall_m_valid", {63'd0, m_valid}, 64'd1);
                check("t3_stall_no_out", 64'(out_log.size()), 64'd0);
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        do_flush("t3");
        check("t3_out_cnt", 64'(out_log.size()), 64'd40);
        for (int i = 0; i < 40; i++) begin
            v = IW'(i * 1237 - 20000);
            if (i < out_log.size()) check("t3_out", out_log[i], sext(v));
        end

        // Extremes
        clear_logs();
        send(16'h8000);
        send(16'h7FFF);
        do_flush("t4");
        check("t4_out_cnt", 64'(out_log.size()), 64'd2);
        if (out_log.size() >= 2) begin
            check("t4_min", out_log[0], 64'hFFFF_FFFF_FFFF_8000);
            check("t4_max", out_log[1], 64'h0000_0000_0000_7FFF);
        end

        // Reset during DRAIN, then restart
        clear_logs();
        send(16'd11);
        send(16'd12);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_in_drain", {63'd0, dbg_state}, 64'd1);
        reset_n = 1'b0;
        pend_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("t5_rst_state", {63'd0, dbg_state}, 64'd0);
        check("t5_rst_m_valid", {63'd0, m_valid}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mv_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (m_valid) mv_seen++;
        end
        check("t5_no_stale", 64'(mv_seen), 64'd0);
        @(posedge clk); #1;
        clear_logs();
        send(16'd21);
        send(16'd22);
        send(16'd23);
        do_flush("t5");
        check("t5_out_cnt", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < out_log.size()) check("t5_out", out_log[i], 64'(i + 21));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fir_l3_stream_ctrl.md
Name: fir_l3_stream_ctrl

Overview:
- Sequencer between a serial 16-bit sample stream and the 3-lane parallel pipelined FIR (FIR_Filter_L3_Top with a clock-enable input).
- Packs three consecutive samples into one parallel beat and strobes the FIR clock enable once per beat.
- Tracks which pipeline beats carry real samples and buffers the FIR results, then re-serialises them onto a valid/ready output stream.
- Provides a flush/drain sequence so tail samples emerge without new input.

Parameters:
- DATA_IN_WIDTH, 16, input sample width (signed).
- DATA_OUT_WIDTH, 64, FIR output width (signed).
- FIR_LATENCY, 4, number of ce-beats from a beat's issue to its result on data_out_1..3 (>=1).
- OBUF_BEATS, 4, output buffer depth in 3-lane entries (power of 2, >=2).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- s_valid, in, 1, input sample valid.
- s_ready, out, 1, input sample accepted when s_valid & s_ready.
- s_data, in, DATA_IN_WIDTH, signed input sample.
- flush, in, 1, pulse: drain the partial group and the pipeline.
- fir_ce, out, 1, FIR clock enable; one beat per high cycle.
- fir_data_1/2/3, out, DATA_IN_WIDTH each, lane samples to FIR data_in_1..3. Lane 1 is the oldest.
- fir_out_1/2/3, in, DATA_OUT_WIDTH each, FIR data_out_1..3 (registered in the FIR).
- m_valid, out, 1, output sample valid.
- m_ready, in, 1, downstream ready.
- m_data, out, DATA_OUT_WIDTH, filtered sample.
- busy, out, 1, high in DRAIN or while the output buffer is non-empty.
- flush_done, out, 1, single-cycle pulse when the drain completes.

Behaviour:
- Reset (async, active low) clears the following:
  - fir_ce, fir_data_*, m_valid, m_data, flush_done, busy, lane_cnt, tag line, buffer pointers.
  - State goes to COLLECT.
  - s_ready is 1 in the first cycle after reset.
- Group assembly:
  - Group register has lane_cnt 0..3. Accepted samples fill lanes 1, 2, 3 in arrival order.
  - s_ready = (state==COLLECT) & (lane_cnt<3 | issue). A sample accepted in an issue cycle becomes lane 1 of the next group.
- Credit:
  - can_issue = (obuf free entries − pending_push) >= 1.
  - pending_push = the tail tag was nonzero on the previous ce.
- Issue:
  - In COLLECT, issue occurs when lane_cnt==3 & can_issue.
  - On issue: fir_ce=1 for exactly one cycle, fir_data_* hold the group, lane_cnt <= 0 (or 1 if a sample is accepted in the same cycle).
  - fir_data_* remain stable between ce pulses.
- Tag line:
  - FIR_LATENCY entries of 2 bits (real lane count 0..3). Shifts only on fir_ce; tag[0] <= lane count of the issued beat.
  - The tail tag describes the beat whose result the FIR presents in the cycle after that ce.
- Capture:
  - In the cycle after a ce, if the tail tag is nonzero, push {tag, fir_out_1..3} into the output buffer.
  - An entry with tag 0 is discarded.
- Serialiser:
  - Head entry emits lanes 1..tag in order on m_data with m_valid.
  - A lane advances on m_valid & m_ready. The entry pops after the last real lane is accepted.
  - m_data/m_valid are registered. m_valid stays high and m_data stays stable under m_ready=0.
- FSM COLLECT: if flush is sampled high, go to DRAIN with drain_cnt=FIR_LATENCY. A sample accepted in the same cycle is included in the group.
- FSM DRAIN:
  - s_ready=0; flush is ignored.
  - Each beat issues when can_issue, decrementing drain_cnt.
  - The first drain beat carries the partial group, zero-padded, with tag=lane_cnt (may be 0). Later beats are all-zero with tag 0.
  - When drain_cnt==0 and no push is pending: flush_done=1 for one cycle, then COLLECT. Filter history is now zero; the stream restarts.
- Without flush, results stay in the pipeline until enough later beats are issued. This is intentional.
- Output buffer full: issue stalls, lane_cnt holds at 3, s_ready drops. No sample is lost or reordered.
- Reset mid-operation: all in-flight tags and buffered results are discarded, with no m_valid afterwards. The bench resets the FIR concurrently.

Decomposition:
- Package fir_l3_pkg:
  - L=3 constant.
  - lane_cnt_t (2-bit).
  - state_t enum {COLLECT, DRAIN}.
  - obuf_entry_t struct {tag, lane[3]}.
- One sub-module: fir_l3_obuf, a synchronous FIFO of obuf_entry_t with count/free outputs.

Test Plan:
All cases use FIR_LATENCY=4, OBUF_BEATS=4, and an identity FIR stub (4-beat ce-gated delay, sign extension).
- Reset: hold reset_n=0 → all outputs 0, busy=0. After release, s_ready=1 and fir_ce stays 0 with no input.
- Samples 1..6, m_ready=1 → fir_ce pulses twice with (1,2,3) then (4,5,6); no m_valid yet. Then flush → 4 zero beats; m_data emits 1,2,3,4,5,6 in order; flush_done pulses once; busy falls after it.
- Samples 7..10 then flush → first drain beat is (10,0,0) with tag 1; outputs exactly 7,8,9,10, no padding zeros emitted.
- m_ready=0, 40 samples streamed → fir_ce stops once the buffer is full; s_ready=0; m_data holds. Then m_ready=1 → all 40 results in order, none duplicated.
- s_data=−32768 and 32767 → m_data=0xFFFF_FFFF_FFFF_8000 and 0x0000_0000_0000_7FFF.
- reset_n pulsed low during DRAIN → state COLLECT, m_valid=0, no stale output. A new 3-sample group then filters correctly.
